// File: rtl/hilo_muldiv_unit_pkg.sv
// hilo_muldiv_unit_pkg: op codes, FSM states and the wide-product helper for the HI/LO muldiv unit.
package hilo_muldiv_unit_pkg;

   localparam int MAX_W = 64;

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_MADD  = 4'd2;
   localparam logic [3:0] OP_MADDU = 4'd3;
   localparam logic [3:0] OP_MSUB  = 4'd4;
   localparam logic [3:0] OP_MSUBU = 4'd5;
   localparam logic [3:0] OP_DIV   = 4'd6;
   localparam logic [3:0] OP_DIVU  = 4'd7;
   localparam logic [3:0] OP_MTHI  = 4'd8;
   localparam logic [3:0] OP_MTLO  = 4'd9;

   typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_FIX} state_t;

   // Widen a w-bit operand to 2*MAX_W bits, sign- or zero-extending from bit w-1.
   function automatic logic [2*MAX_W-1:0] extend(input logic [MAX_W-1:0] a, input int w, input logic sgn);
      logic [2*MAX_W-1:0] t;
      t = {{MAX_W{1'b0}}, a} << (2*MAX_W - w);
      return sgn ? $unsigned($signed(t) >>> (2*MAX_W - w)) : t >> (2*MAX_W - w);
   endfunction

   // Low 2*w bits of the result are the exact signed/unsigned product of two w-bit operands.
   function automatic logic [2*MAX_W-1:0] wide_product(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                                      input int w, input logic sgn);
      return extend(a, w, sgn) * extend(b, w, sgn);
   endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div_iter_core.sv
// div_iter_core: unsigned restoring divider, one quotient bit per enabled cycle.
module div_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             last
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [CW-1:0]    count;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   shifted;
   logic             ge;

   // The dividend lives in the quotient register and is shifted out MSB-first as quotient bits shift in.
   always_comb begin
      shifted = {remainder, quotient[WIDTH-1]};
      ge      = shifted >= {1'b0, dvs};
      last    = count == CW'(WIDTH - 1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count     <= '0;
         dvs       <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else if (load) begin
         count     <= '0;
         dvs       <= divisor;
         quotient  <= dividend;
         remainder <= '0;
      end else if (step) begin
         count     <= count + CW'(1);
         quotient  <= {quotient[WIDTH-2:0], ge};
         remainder <= ge ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: EX-stage multiply/accumulate and iterative divide with an owned HI/LO register pair.
module hilo_muldiv_unit
   import hilo_muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [3:0]       Op,
   input  logic [WIDTH-1:0] OperandA,
   input  logic [WIDTH-1:0] OperandB,
   input  logic             Flush,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] HiOut,
   output logic [WIDTH-1:0] LoOut
);

   localparam int W2 = 2 * WIDTH;

   state_t           state;
   logic [WIDTH-1:0] hi, lo, a_hold, a_mag, b_mag, quo, rem;
   logic [W2-1:0]    hilo, prod, acc_res;
   logic             is_div, is_signed, op_ok, go, last, neg_q, neg_r, dz;

   always_comb begin
      is_div    = Op == OP_DIV || Op == OP_DIVU;
      is_signed = Op == OP_MULT || Op == OP_MADD || Op == OP_MSUB || Op == OP_DIV;
      op_ok     = Op <= OP_MTLO;
      go        = Start && !Flush && state == ST_IDLE;
      a_mag     = (is_signed && OperandA[WIDTH-1]) ? -OperandA : OperandA;
      b_mag     = (is_signed && OperandB[WIDTH-1]) ? -OperandB : OperandB;
      prod      = W2'(wide_product(MAX_W'(OperandA), MAX_W'(OperandB), WIDTH, is_signed));
      hilo      = {hi, lo};
      acc_res   = (Op == OP_MULT || Op == OP_MULTU) ? prod :
                  (Op == OP_MADD || Op == OP_MADDU) ? hilo + prod :
                  (Op == OP_MSUB || Op == OP_MSUBU) ? hilo - prod :
                  (Op == OP_MTHI) ? {OperandA, lo} : {hi, OperandA};
   end

   div_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk       (Clk),
      .rst_n     (Rst),
      .load      (go && is_div),
      .step      (state == ST_DIV && !Flush),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (quo),
      .remainder (rem),
      .last      (last)
   );

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state  <= ST_IDLE;
         hi     <= '0;
         lo     <= '0;
         Done   <= 1'b0;
         a_hold <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
      end else begin
         Done <= 1'b0;
         if (go && is_div) begin
            state  <= ST_DIV;
            a_hold <= OperandA;
            dz     <= OperandB == '0;
            neg_q  <= is_signed && (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
            neg_r  <= is_signed && OperandA[WIDTH-1];
         end else if (go && op_ok) begin
            {hi, lo} <= acc_res;
            Done     <= 1'b1;
         end else if (state == ST_DIV) begin
            state <= Flush ? ST_IDLE : last ? ST_FIX : ST_DIV;
         end else if (state == ST_FIX) begin
            state <= ST_IDLE;
            // Divide by zero keeps the dividend in HI; the sign fix-up is bypassed.
            if (!Flush) begin
               hi   <= dz ? a_hold : neg_r ? -rem : rem;
               lo   <= dz ? '1 : neg_q ? -quo : quo;
               Done <= 1'b1;
            end
         end
      end
   end

   assign Busy  = state != ST_IDLE;
   assign HiOut = hi;
   assign LoOut = lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed and random checks of 32-bit and 8-bit instances against a cycle-level reference model.
module tb_hilo_muldiv_unit;
   import hilo_muldiv_unit_pkg::*;

   logic        Clk = 1'b0, Rst = 1'b0, Flush = 1'b0, st0 = 1'b0, st1 = 1'b0, cmp_en = 1'b0;
   logic [3:0]  Op = 4'd0;
   logic [31:0] a0 = '0, b0 = '0, hi0, lo0;
   logic [7:0]  a1 = '0, b1 = '0, hi1, lo1;
   logic        busy0, done0, busy1, done1;
   int          n_checks = 0, n_fail = 0, cyc;

   logic [31:0] m_hi[2], m_lo[2], p_hi[2], p_lo[2];
   logic        m_busy[2], m_done[2];
   int          m_cnt[2];

   always #5 Clk = ~Clk;

   hilo_muldiv_unit #(.WIDTH(32)) dut32 (
      .Clk(Clk), .Rst(Rst), .Start(st0), .Op(Op), .OperandA(a0), .OperandB(b0), .Flush(Flush),
      .Busy(busy0), .Done(done0), .HiOut(hi0), .LoOut(lo0));

   hilo_muldiv_unit #(.WIDTH(8)) dut8 (
      .Clk(Clk), .Rst(Rst), .Start(st1), .Op(Op), .OperandA(a1), .OperandB(b1), .Flush(Flush),
      .Busy(busy1), .Done(done1), .HiOut(hi1), .LoOut(lo1));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ext(input logic [31:0] x, input int w, input logic sgn);
      logic [63:0] m, v;
      m = (64'h1 << w) - 64'h1;
      v = {32'h0, x} & m;
      if (sgn && ((v >> (w - 1)) & 64'h1) != 64'h0) v = v | ~m;
      return v;
   endfunction

   // Reference: non-divides commit at the sampling edge; a divide commits w+1 edges later unless flushed.
   task automatic model_step(input int i, input int w, input logic st, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] m, m2, acc, p, r;
      logic        sg, upd;
      longint      sx, sy;
      m   = (64'h1 << w) - 64'h1;
      m2  = (w == 32) ? '1 : (64'h1 << (2 * w)) - 64'h1;
      sg  = Op == OP_MULT || Op == OP_MADD || Op == OP_MSUB || Op == OP_DIV;
      upd = 1'b1;
      if (!Rst) begin
         m_hi[i] = '0; m_lo[i] = '0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_cnt[i] = 0;
      end else begin
         m_done[i] = 1'b0;
         if (m_busy[i]) begin
            if (Flush) m_busy[i] = 1'b0;
            else begin
               m_cnt[i]--;
               if (m_cnt[i] == 0) begin
                  m_busy[i] = 1'b0; m_hi[i] = p_hi[i]; m_lo[i] = p_lo[i]; m_done[i] = 1'b1;
               end
            end
         end else if (st && !Flush) begin
            acc = ({32'h0, m_hi[i]} << w) | {32'h0, m_lo[i]};
            p   = (ext(a, w, sg) * ext(b, w, sg)) & m2;
            r   = acc;
            case (Op)
               OP_MULT, OP_MULTU: r = p;
               OP_MADD, OP_MADDU: r = (acc + p) & m2;
               OP_MSUB, OP_MSUBU: r = (acc - p) & m2;
               OP_MTHI: r = ({32'h0, a} << w) | {32'h0, m_lo[i]};
               OP_MTLO: r = ({32'h0, m_hi[i]} << w) | {32'h0, a};
               OP_DIV, OP_DIVU: begin
                  upd = 1'b0; m_busy[i] = 1'b1; m_cnt[i] = w + 1;
                  if (b == 0) begin
                     p_lo[i] = 32'(m); p_hi[i] = a;
                  end else if (sg) begin
                     sx = $signed(ext(a, w, 1'b1)); sy = $signed(ext(b, w, 1'b1));
                     p_lo[i] = 32'(64'(sx / sy) & m); p_hi[i] = 32'(64'(sx % sy) & m);
                  end else begin
                     p_lo[i] = a / b; p_hi[i] = a % b;
                  end
               end
               default: upd = 1'b0;
            endcase
            if (upd) begin
               m_hi[i] = 32'(r >> w); m_lo[i] = 32'(r & m); m_done[i] = 1'b1;
            end
         end
      end
   endtask

   always @(posedge Clk) begin
      model_step(0, 32, st0, a0, b0);
      model_step(1, 8, st1, {24'h0, a1}, {24'h0, b1});
   end

   always @(posedge Clk) begin
      #1;
      if (cmp_en) begin
         chk("hi32", {32'h0, hi0}, {32'h0, m_hi[0]});
         chk("lo32", {32'h0, lo0}, {32'h0, m_lo[0]});
         chk("busy32", {63'h0, busy0}, {63'h0, m_busy[0]});
         chk("done32", {63'h0, done0}, {63'h0, m_done[0]});
         chk("hi8", {56'h0, hi1}, {32'h0, m_hi[1]});
         chk("lo8", {56'h0, lo1}, {32'h0, m_lo[1]});
         chk("busy8", {63'h0, busy1}, {63'h0, m_busy[1]});
         chk("done8", {63'h0, done1}, {63'h0, m_done[1]});
      end
   end

   task automatic issue(input int sel, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      Op = op;
      if (sel == 0) begin st0 = 1'b1; a0 = a; b0 = b; end
      else begin st1 = 1'b1; a1 = a[7:0]; b1 = b[7:0]; end
      @(negedge Clk);
      st0 = 1'b0; st1 = 1'b0;
   endtask

   task automatic wait_idle(input int sel, output int c);
      c = 0;
      while ((sel == 0 ? busy0 : busy1) && c < 100) begin
         c++;
         @(negedge Clk);
      end
      if (c >= 100) chk("busy_timeout", 64'(c), 64'd0);
   endtask

   logic [3:0] ops[8] = '{OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU};

   initial begin
      repeat (2) @(negedge Clk);
      cmp_en = 1'b1;
      Rst    = 1'b1;
      chk("rst_hi", {32'h0, hi0}, 64'h0);
      chk("rst_lo", {32'h0, lo0}, 64'h0);
      chk("rst_busy", {63'h0, busy0}, 64'h0);
      chk("rst_done", {63'h0, done0}, 64'h0);
      @(negedge Clk);

      issue(0, OP_MULT, 32'hFFFFFFFD, 32'd7);
      chk("mult_hi", {32'h0, hi0}, 64'hFFFFFFFF);
      chk("mult_lo", {32'h0, lo0}, 64'hFFFFFFEB);
      chk("mult_done", {63'h0, done0}, 64'h1);
      chk("mult_busy", {63'h0, busy0}, 64'h0);

      issue(0, OP_MTHI, 32'd0, 32'd0);
      issue(0, OP_MTLO, 32'd10, 32'd0);
      issue(0, OP_MADDU, 32'hFFFFFFFF, 32'd2);
      chk("maddu_hi", {32'h0, hi0}, 64'h2);
      chk("maddu_lo", {32'h0, lo0}, 64'h8);
      issue(0, OP_MSUB, 32'd1, 32'd8);
      chk("msub_hi", {32'h0, hi0}, 64'h2);
      chk("msub_lo", {32'h0, lo0}, 64'h0);

      issue(0, OP_MULT, 32'd5, 32'd6);
      issue(0, OP_MADD, 32'd2, 32'd3);
      chk("b2b_madd_lo", {32'h0, lo0}, 64'd36);
      issue(0, 4'hF, 32'd1, 32'd1);
      chk("badop_done", {63'h0, done0}, 64'h0);

      Flush = 1'b1;
      issue(0, OP_DIVU, 32'd9, 32'd3);
      Flush = 1'b0;
      chk("flush_start_busy", {63'h0, busy0}, 64'h0);

      issue(0, OP_DIV, 32'hFFFFFFF9, 32'd2);
      wait_idle(0, cyc);
      chk("div_busy_cycles", 64'(cyc), 64'd33);
      chk("div_done", {63'h0, done0}, 64'h1);
      chk("div_lo", {32'h0, lo0}, 64'hFFFFFFFD);
      chk("div_hi", {32'h0, hi0}, 64'hFFFFFFFF);

      issue(0, OP_DIVU, 32'd100, 32'd0);
      wait_idle(0, cyc);
      chk("dz_lo", {32'h0, lo0}, 64'hFFFFFFFF);
      chk("dz_hi", {32'h0, hi0}, 64'd100);

      issue(0, OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_idle(0, cyc);
      chk("ovf_lo", {32'h0, lo0}, 64'h80000000);
      chk("ovf_hi", {32'h0, hi0}, 64'h0);

      issue(0, OP_DIVU, 32'd1000, 32'd7);
      repeat (8) @(negedge Clk);
      Flush = 1'b1;
      @(negedge Clk);
      Flush = 1'b0;
      chk("flush_busy", {63'h0, busy0}, 64'h0);
      chk("flush_done", {63'h0, done0}, 64'h0);
      chk("flush_lo", {32'h0, lo0}, 64'h80000000);
      repeat (3) @(negedge Clk);

      issue(0, OP_DIVU, 32'd50, 32'd5);
      issue(0, OP_MULT, 32'd9, 32'd9);
      wait_idle(0, cyc);
      chk("ignored_start_lo", {32'h0, lo0}, 64'd10);

      issue(0, OP_DIVU, 32'd1000, 32'd7);
      repeat (5) @(negedge Clk);
      Rst = 1'b0;
      @(negedge Clk);
      Rst = 1'b1;
      chk("midrst_busy", {63'h0, busy0}, 64'h0);
      chk("midrst_lo", {32'h0, lo0}, 64'h0);
      chk("midrst_hi", {32'h0, hi0}, 64'h0);

      issue(1, OP_DIVU, 32'd200, 32'd7);
      wait_idle(1, cyc);
      chk("w8_div_cycles", 64'(cyc), 64'd9);
      chk("w8_div_lo", {56'h0, lo1}, 64'd28);
      chk("w8_div_hi", {56'h0, hi1}, 64'd4);
      issue(1, OP_DIV, 32'h80, 32'hFF);
      wait_idle(1, cyc);
      chk("w8_ovf_lo", {56'h0, lo1}, 64'h80);

      for (int i = 0; i < 40; i++) begin
         issue(1, ops[$urandom_range(0, 7)], $urandom, (i % 7 == 0) ? 32'd0 : $urandom);
         wait_idle(1, cyc);
      end
      for (int i = 0; i < 12; i++) begin
         issue(0, ops[$urandom_range(0, 7)], $urandom, (i % 5 == 0) ? 32'd0 : $urandom);
         wait_idle(0, cyc);
      end
      repeat (2) @(negedge Clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
